// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection; feeds the alu operands and op code directly.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic [3:0]        alu_control_in,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              uses_rt,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_valid,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              load_use_hazard
);

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              alu_src_q;
    logic              uses_rt_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;

    fwd_sel_e          sel_a;
    fwd_sel_e          sel_b;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Reset and flush both produce an all-zero bubble; flush overrides stall.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
            uses_rt_q    <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            alu_control  <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_valid     <= 1'b0;
        end else if (!stall) begin
            rs_data_q    <= rs_data;
            rt_data_q    <= rt_data;
            imm_q        <= imm;
            alu_src_q    <= alu_src;
            uses_rt_q    <= uses_rt;
            rs_q         <= rs_addr;
            rt_q         <= rt_addr;
            alu_control  <= alu_control_in;
            ex_rd        <= rd_addr;
            ex_reg_write <= reg_write_in & in_valid;
            ex_mem_read  <= mem_read_in & in_valid;
            ex_valid     <= in_valid;
        end
    end

    // Register 0 is never forwarded; EX/MEM is the younger producer and wins.
    always_comb begin
        sel_a  = FWD_REG;
        fwd_rs = rs_data_q;
        if ((rs_q != '0) && exmem_reg_write && (exmem_rd == rs_q)) begin
            sel_a  = FWD_EXMEM;
            fwd_rs = exmem_result;
        end else if ((rs_q != '0) && memwb_reg_write && (memwb_rd == rs_q)) begin
            sel_a  = FWD_MEMWB;
            fwd_rs = memwb_data;
        end
    end

    always_comb begin
        sel_b  = FWD_REG;
        fwd_rt = rt_data_q;
        if (uses_rt_q && (rt_q != '0) && exmem_reg_write && (exmem_rd == rt_q)) begin
            sel_b  = FWD_EXMEM;
            fwd_rt = exmem_result;
        end else if (uses_rt_q && (rt_q != '0) && memwb_reg_write && (memwb_rd == rt_q)) begin
            sel_b  = FWD_MEMWB;
            fwd_rt = memwb_data;
        end
    end

    always_comb begin
        alu_a      = fwd_rs;
        store_data = fwd_rt;
        alu_b      = alu_src_q ? imm_q : fwd_rt;
        fwd_a_sel  = sel_a;
        fwd_b_sel  = sel_b;
    end

    always_comb begin
        load_use_hazard = ex_valid & ex_mem_read & (ex_rd != '0) & in_valid &
                          ((ex_rd == rs_addr) | (uses_rt & (ex_rd == rt_addr)));
    end

endmodule
